// File: rtl/wvb_rd_sched.sv
// Waveform-buffer read scheduler: grants a channel, pops its header, streams its words, signals completion.
// Define WVB_RD_SCHED_FIXED_PRIO_EN for fixed-priority grant (lowest non-empty channel); default is round-robin.
module wvb_rd_sched #(
  parameter int P_N_CHAN    = 4,
  parameter int P_ADR_WIDTH = 12,
  parameter int P_HDR_WAIT  = 3,
  parameter int P_RD_LAT    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [P_N_CHAN-1:0]             hdr_empty,
  input  logic [P_N_CHAN*P_ADR_WIDTH-1:0] hdr_start_addr,
  input  logic [P_N_CHAN*P_ADR_WIDTH-1:0] hdr_stop_addr,
  input  logic                            out_ready,
  output logic [P_N_CHAN-1:0]             hdr_rdreq,
  output logic [P_N_CHAN-1:0]             wvb_rdreq,
  output logic [P_N_CHAN-1:0]             wvb_rddone,
  output logic                            out_valid,
  output logic                            out_sop,
  output logic                            out_eop,
  output logic [2:0]                      out_chan,
  output logic                            busy
);

  localparam int LP_CNT_W  = P_ADR_WIDTH + 1;
  localparam int LP_WAIT_W = (P_HDR_WAIT > 2) ? $clog2(P_HDR_WAIT) : 1;

  typedef enum logic [2:0] {IDLE, HDR_POP, HDR_WAIT, STREAM, DONE} state_t;

  typedef struct packed {
    logic       vld;
    logic       sop;
    logic       eop;
    logic [2:0] chan;
  } rd_tag_t;

  state_t                 state_q, state_d;
  logic [2:0]             sel_q;
  logic [LP_CNT_W-1:0]    count_q;
  logic [LP_WAIT_W-1:0]   wait_cnt;
  logic                   first_q;
  logic                   gnt_vld;
  logic [2:0]             gnt_idx;
  logic [P_ADR_WIDTH-1:0] gnt_start, gnt_stop, gnt_words;
  logic [LP_CNT_W-1:0]    gnt_count;
  logic [P_N_CHAN-1:0]    sel_oh;
  logic                   issue, last_word, do_grant;
  rd_tag_t                tag_in, tag_out;

`ifdef WVB_RD_SCHED_FIXED_PRIO_EN
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = P_N_CHAN - 1; i >= 0; i--) begin
      if (!hdr_empty[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = 3'(i);
      end
    end
  end
`else
  logic [2:0] rr_last;
  int         rr_cand;

  // Walk the search order backwards so the first candidate after rr_last is the one left standing.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_cand = 0;
    for (int i = P_N_CHAN - 1; i >= 0; i--) begin
      rr_cand = int'(rr_last) + 1 + i;
      if (rr_cand >= P_N_CHAN) rr_cand = rr_cand - P_N_CHAN;
      if (!hdr_empty[rr_cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = 3'(rr_cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           rr_last <= 3'(P_N_CHAN - 1);
    else if (do_grant) rr_last <= gnt_idx;
  end
`endif

  assign do_grant  = (state_q == IDLE) && en && gnt_vld;
  assign gnt_start = hdr_start_addr[gnt_idx*P_ADR_WIDTH +: P_ADR_WIDTH];
  assign gnt_stop  = hdr_stop_addr[gnt_idx*P_ADR_WIDTH +: P_ADR_WIDTH];
  assign gnt_words = gnt_stop - gnt_start + P_ADR_WIDTH'(1);
  // A zero modular length is a full-buffer wrap, so the extra count bit holds 2^P_ADR_WIDTH.
  assign gnt_count = (gnt_words == '0) ? {1'b1, {P_ADR_WIDTH{1'b0}}} : {1'b0, gnt_words};

  assign issue     = (state_q == STREAM) && out_ready;
  assign last_word = (count_q == LP_CNT_W'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (do_grant) state_d = HDR_POP;
      HDR_POP:  state_d = (P_HDR_WAIT == 0) ? STREAM : HDR_WAIT;
      HDR_WAIT: if (wait_cnt == '0) state_d = STREAM;
      STREAM:   if (issue && last_word) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      count_q  <= '0;
      wait_cnt <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (do_grant) begin
          sel_q   <= gnt_idx;
          count_q <= gnt_count;
        end
        HDR_POP: begin
          wait_cnt <= LP_WAIT_W'(P_HDR_WAIT - 1);
          first_q  <= 1'b1;
        end
        HDR_WAIT: wait_cnt <= wait_cnt - LP_WAIT_W'(1);
        STREAM: if (issue) begin
          count_q <= count_q - LP_CNT_W'(1);
          first_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign sel_oh = P_N_CHAN'(1) << sel_q;

  always_comb begin
    hdr_rdreq  = '0;
    wvb_rdreq  = '0;
    wvb_rddone = '0;
    if (state_q == HDR_POP) hdr_rdreq  = sel_oh;
    if (issue)              wvb_rdreq  = sel_oh;
    if (state_q == DONE)    wvb_rddone = sel_oh;
  end

  assign busy   = (state_q != IDLE);
  assign tag_in = '{vld: issue, sop: issue & first_q, eop: issue & last_word, chan: sel_q};

  generate
    if (P_RD_LAT == 0) begin : g_no_lat
      assign tag_out = tag_in;
    end else begin : g_lat
      rd_tag_t pipe [P_RD_LAT];
      // NOTE: this small delay line is reset stage by stage because stale valids must not escape after rst.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < P_RD_LAT; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= tag_in;
          for (int i = 1; i < P_RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign tag_out = pipe[P_RD_LAT-1];
    end
  endgenerate

  assign out_valid = tag_out.vld;
  assign out_sop   = tag_out.sop;
  assign out_eop   = tag_out.eop;
  assign out_chan  = tag_out.chan;

endmodule

// File: tb/tb_wvb_rd_sched.sv
// Self-checking bench for wvb_rd_sched: table of single-channel waveforms plus grant-order and reset sequences.
module tb_wvb_rd_sched;

  localparam int N   = 4;
  localparam int W   = 12;
  localparam int HW  = 3;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst, en, out_ready;
  logic [N-1:0]   hdr_empty;
  logic [N*W-1:0] hdr_start_addr, hdr_stop_addr;
  logic [N-1:0]   hdr_rdreq, wvb_rdreq, wvb_rddone;
  logic           out_valid, out_sop, out_eop, busy;
  logic [2:0]     out_chan;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int chan;
    int start;
    int stop;
    int stall_after;
    int exp_words;
  } vec_t;

  vec_t vecs [6];

  wvb_rd_sched #(.P_N_CHAN(N), .P_ADR_WIDTH(W), .P_HDR_WAIT(HW), .P_RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .hdr_empty(hdr_empty),
    .hdr_start_addr(hdr_start_addr), .hdr_stop_addr(hdr_stop_addr), .out_ready(out_ready),
    .hdr_rdreq(hdr_rdreq), .wvb_rdreq(wvb_rdreq), .wvb_rddone(wvb_rddone),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_chan(out_chan), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_addr(input int ch, input int s, input int e);
    hdr_start_addr[ch*W +: W] = W'(s);
    hdr_stop_addr[ch*W +: W]  = W'(e);
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Drives one table entry through a complete waveform and checks timing, counts and framing.
  task automatic run_wave(input int idx);
    vec_t v;
    int cyc = 0, hdr_cyc = -1, hdr_n = 0, issued = 0, first_iss = -1, last_iss = -1;
    int done_n = 0, done_cyc = -1, vcnt = 0, first_v = -1, sop_pos = -1, eop_pos = -1;
    int eop_cyc = -1, bad = 0, stall_n = 0, span;
    bit hdr_taken = 0, timeout = 0;
    logic [N-1:0] oh;
    v = vecs[idx];
    oh = '0;
    oh[v.chan] = 1'b1;
    for (int c = 0; c < N; c++) set_addr(c, 0, 99);
    set_addr(v.chan, v.start, v.stop);
    hdr_empty = ~oh;
    en = 1'b1;
    out_ready = 1'b1;
    while (done_cyc < 0 || cyc < done_cyc + LAT + 2) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 9000) begin timeout = 1; break; end
      if (hdr_taken) begin hdr_empty = '1; en = 1'b0; end
      if (v.stall_after > 0 && issued == v.stall_after && stall_n < 5) begin
        out_ready = 1'b0;
        stall_n++;
      end else out_ready = 1'b1;
      #1;
      if (!$onehot0(hdr_rdreq) || !$onehot0(wvb_rdreq) || !$onehot0(wvb_rddone)) bad++;
      if (|hdr_rdreq) begin
        hdr_n++; hdr_cyc = cyc; hdr_taken = 1;
        if (hdr_rdreq != oh) bad++;
      end
      if (|wvb_rdreq) begin
        if (first_iss < 0) first_iss = cyc;
        last_iss = cyc; issued++;
        if (wvb_rdreq != oh || !out_ready) bad++;
      end
      if (|wvb_rddone) begin
        done_n++; done_cyc = cyc;
        if (wvb_rddone != oh) bad++;
      end
      if (out_valid) begin
        vcnt++;
        if (first_v < 0) first_v = cyc;
        if (out_sop) sop_pos = vcnt;
        if (out_eop) begin eop_pos = vcnt; eop_cyc = cyc; end
        if (int'(out_chan) != v.chan) bad++;
      end
    end
    span = v.exp_words - 1 + ((v.stall_after > 0) ? 5 : 0);
    check($sformatf("v%0d_timeout", idx), timeout, 0);
    check($sformatf("v%0d_hdr_pulses", idx), hdr_n, 1);
    check($sformatf("v%0d_hdr_to_rd", idx), first_iss - hdr_cyc, HW + 1);
    check($sformatf("v%0d_words", idx), issued, v.exp_words);
    check($sformatf("v%0d_span", idx), last_iss - first_iss, span);
    check($sformatf("v%0d_done_pulses", idx), done_n, 1);
    check($sformatf("v%0d_done_gap", idx), done_cyc - last_iss, 1);
    check($sformatf("v%0d_valid_cnt", idx), vcnt, v.exp_words);
    check($sformatf("v%0d_valid_lat", idx), first_v - first_iss, LAT);
    check($sformatf("v%0d_sop_pos", idx), sop_pos, 1);
    check($sformatf("v%0d_eop_pos", idx), eop_pos, v.exp_words);
    check($sformatf("v%0d_eop_lat", idx), eop_cyc - last_iss, LAT);
    check($sformatf("v%0d_strobe_errs", idx), bad, 0);
    check($sformatf("v%0d_busy_end", idx), busy, 0);
  endtask

  initial begin
    int gnt [5];
    int gap [5];
    int exp_gnt [5];
    int g, cyc, last_done, bad, issued, seen;

    vecs[0] = '{chan: 1, start: 10,   stop: 13,   stall_after: 0, exp_words: 4};
    vecs[1] = '{chan: 2, start: 4094, stop: 1,    stall_after: 0, exp_words: 4};
    vecs[2] = '{chan: 0, start: 5,    stop: 4,    stall_after: 0, exp_words: 4096};
    vecs[3] = '{chan: 1, start: 100,  stop: 109,  stall_after: 3, exp_words: 10};
    vecs[4] = '{chan: 2, start: 7,    stop: 7,    stall_after: 0, exp_words: 1};
    vecs[5] = '{chan: 3, start: 0,    stop: 4095, stall_after: 0, exp_words: 4096};

`ifdef WVB_RD_SCHED_FIXED_PRIO_EN
    exp_gnt = '{0, 0, 0, 0, 0};
`else
    exp_gnt = '{0, 1, 2, 3, 0};
`endif

    rst = 1'b1; en = 1'b0; out_ready = 1'b1; hdr_empty = '1;
    hdr_start_addr = '0; hdr_stop_addr = '0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_outputs", {hdr_rdreq, wvb_rdreq, wvb_rddone, out_valid, out_sop, out_eop, out_chan}, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;

    // en low in IDLE must hold off any grant.
    hdr_empty = 4'b1101;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #2;
      if (busy || |hdr_rdreq) seen++;
    end
    check("en_low_no_grant", seen, 0);
    hdr_empty = '1;

    for (int i = 0; i < 6; i++) run_wave(i);

    // All channels permanently non-empty: grant order and back-to-back spacing.
    for (int c = 0; c < N; c++) set_addr(c, 20 + c, 20 + c);
    hdr_empty = '0; en = 1'b1; out_ready = 1'b1;
    g = 0; cyc = 0; last_done = -1; bad = 0;
    while (g < 5 && cyc < 300) begin
      @(posedge clk); #2;
      cyc++;
      if (!$onehot0(hdr_rdreq) || !$onehot0(wvb_rdreq) || !$onehot0(wvb_rddone)) bad++;
      if (|hdr_rdreq) begin
        gnt[g] = oh_idx(hdr_rdreq);
        gap[g] = cyc - last_done;
        g++;
      end
      if (|wvb_rddone) last_done = cyc;
    end
    en = 1'b0;
    check("rr_grant_count", g, 5);
    for (int i = 0; i < 5; i++) begin
      if (i < g) begin
        check($sformatf("rr_grant%0d", i), gnt[i], exp_gnt[i]);
        if (i > 0) check($sformatf("rr_b2b_gap%0d", i), gap[i], 2);
      end
    end
    check("rr_onehot_errs", bad, 0);
    cyc = 0;
    while (busy && cyc < 100) begin @(posedge clk); #2; cyc++; end
    check("rr_drain", busy, 0);

    // Reset in the middle of a stream on channel 2.
    hdr_empty = 4'b1011;
    set_addr(2, 0, 9);
    en = 1'b1;
    issued = 0; cyc = 0;
    while (issued < 2 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (busy) hdr_empty = '1;
      #1;
      if (|wvb_rdreq) issued++;
    end
    check("mid_rst_reached_stream", issued, 2);
    @(posedge clk); #1;
    rst = 1'b1; hdr_empty = '1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_outputs", {hdr_rdreq, wvb_rdreq, wvb_rddone, out_valid, out_sop, out_eop, out_chan}, 0);
    check("mid_rst_busy", busy, 0);
    seen = 0;
    repeat (4) begin
      @(posedge clk); #2;
      if (|wvb_rddone || out_valid) seen++;
    end
    check("mid_rst_no_done_or_valid", seen, 0);

    for (int c = 0; c < N; c++) set_addr(c, 50, 50);
    hdr_empty = '0;
    seen = -1; cyc = 0;
    while (seen < 0 && cyc < 20) begin
      @(posedge clk); #2;
      cyc++;
      if (|hdr_rdreq) begin seen = oh_idx(hdr_rdreq); hdr_empty = '1; en = 1'b0; end
    end
    check("post_rst_first_grant", seen, 0);
    cyc = 0;
    while (busy && cyc < 100) begin @(posedge clk); #2; cyc++; end
    check("post_rst_drain", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
